// File: rtl/sensor_scan_mux.sv
// rtl/sensor_scan_mux.sv - multi-channel sensor sample mux with settle window, valid/ready output and sticky alarm
// Optional continuous sweep on last-channel handshake: define SENSOR_SCAN_CONT_EN.
module sensor_scan_mux #(
  parameter int WIDTH  = 128,
  parameter int NUM_CH = 4,
  parameter int DWELL  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*WIDTH-1:0]     ch_data_i,
  input  logic                        mode_i,
  input  logic [$clog2(NUM_CH)-1:0]   sel_i,
  input  logic                        start_i,
  input  logic [WIDTH-1:0]            thresh_i,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [$clog2(NUM_CH)-1:0]   out_ch_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        busy_o,
  output logic                        alarm_o
);

  localparam int SW  = $clog2(NUM_CH);
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0]  LAST_CH = SW'(NUM_CH - 1);
  localparam logic [DCW-1:0] LAST_DW = DCW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     ch_q, ch_d;
  logic [DCW-1:0]    dw_q, dw_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SW-1:0]     och_q, och_d;
  logic              valid_q, valid_d;
  logic              alarm_q, alarm_d;
  logic              wrap;

  logic [WIDTH-1:0]  chans [NUM_CH];
  logic [WIDTH-1:0]  cur;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign chans[k] = ch_data_i[k*WIDTH +: WIDTH];
  end

  assign cur = chans[ch_q];

`ifdef SENSOR_SCAN_CONT_EN
  assign wrap = start_i;
`else
  assign wrap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dw_d    = dw_q;
    mode_d  = mode_q;
    data_d  = data_q;
    och_d   = och_q;
    valid_d = valid_q;
    alarm_d = alarm_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          // Out-of-range fixed selections clamp to the highest channel.
          if (mode_i)
            ch_d = '0;
          else if ({1'b0, sel_i} >= (SW+1)'(NUM_CH))
            ch_d = LAST_CH;
          else
            ch_d = sel_i;
          dw_d    = '0;
          alarm_d = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        dw_d = dw_q + DCW'(1);
        if (dw_q == LAST_DW) begin
          data_d  = cur;
          och_d   = ch_q;
          valid_d = 1'b1;
          alarm_d = alarm_q | (cur > thresh_i);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && out_ready_i) begin
          valid_d = 1'b0;
          if (mode_q && (ch_q != LAST_CH)) begin
            ch_d    = ch_q + SW'(1);
            dw_d    = '0;
            state_d = SETTLE;
          end else if (mode_q && wrap) begin
            ch_d    = '0;
            dw_d    = '0;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dw_q    <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dw_q    <= dw_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      och_q   <= och_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_ch_o    = och_q;
  assign out_valid_o = valid_q;
  assign alarm_o     = alarm_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_scan_mux.sv
// tb/tb_sensor_scan_mux.sv - bench for sensor_scan_mux: vector table, sample scoreboard, corner sequences
module tb_sensor_scan_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] chv [4];
  logic [511:0] ch_data;
  logic         mode, start, ready;
  logic [1:0]   sel;
  logic [127:0] thresh;
  logic [127:0] out_data;
  logic [1:0]   out_ch;
  logic         out_valid, busy, alarm;

  logic [47:0]  ch_data1;
  logic         start1, valid1, busy1, alarm1;
  logic [1:0]   sel1, ch1;
  logic [15:0]  data1;

  assign ch_data  = {chv[3], chv[2], chv[1], chv[0]};
  assign ch_data1 = {16'hBEEF, 16'h2222, 16'h1111};

  always #5 clk = ~clk;

  sensor_scan_mux #(.WIDTH(128), .NUM_CH(4), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .ch_data_i(ch_data), .mode_i(mode), .sel_i(sel),
    .start_i(start), .thresh_i(thresh), .out_data_o(out_data), .out_ch_o(out_ch),
    .out_valid_o(out_valid), .out_ready_i(ready), .busy_o(busy), .alarm_o(alarm)
  );

  sensor_scan_mux #(.WIDTH(16), .NUM_CH(3), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst), .ch_data_i(ch_data1), .mode_i(1'b0), .sel_i(sel1),
    .start_i(start1), .thresh_i(16'hC000), .out_data_o(data1), .out_ch_o(ch1),
    .out_valid_o(valid1), .out_ready_i(1'b1), .busy_o(busy1), .alarm_o(alarm1)
  );

  typedef struct {
    logic [127:0] data;
    logic [1:0]   ch;
    logic         alarm;
  } exp_t;

  typedef struct {
    logic              mode;
    logic [1:0]        sel;
    logic [3:0][127:0] d;
    logic [127:0]      thr;
    int                cycles;
    logic              alarm;
  } vec_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the samples one start should produce, with the running alarm.
  task automatic push_run(input logic m, input logic [1:0] s, input logic [127:0] thr, input logic a0);
    exp_t e;
    logic a;
    a = a0;
    if (!m) begin
      e.data = chv[s]; e.ch = s; e.alarm = chv[s] > thr;
      q.push_back(e);
    end else begin
      for (int k = 0; k < 4; k++) begin
        a = a | (chv[k] > thr);
        e.data = chv[k]; e.ch = 2'(k); e.alarm = a;
        q.push_back(e);
      end
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [1:0] s,
                              input logic [127:0] d0, d1, d2, d3, thr,
                              input int cyc, input logic al);
    vec_t v;
    v.mode = m; v.sel = s; v.d = {d3, d2, d1, d0}; v.thr = thr;
    v.cycles = cyc; v.alarm = al;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && ready) begin
      if (q.size() == 0) begin
        check("spurious_sample", {126'd0, out_ch}, 128'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sample_data", out_data, e.data);
        check("sample_ch", {126'd0, out_ch}, {126'd0, e.ch});
        check("sample_alarm", {127'd0, alarm}, {127'd0, e.alarm});
      end
    end
  end

  vec_t vecs [5];

  initial begin
    int n, first;
    rst = 1'b1; start = 0; start1 = 0; mode = 0; sel = 0; sel1 = 0; ready = 0; thresh = 0;
    for (int k = 0; k < 4; k++) chv[k] = '0;

    vecs[0] = mk(0, 2'd2, 0, 0, 128'hA5, 0, 128'hFF, 5, 0);
    vecs[1] = mk(1, 2'd0, 1, 2, 3, 4, 128'hFF, 20, 0);
    vecs[2] = mk(1, 2'd0, 5, 11, 5, 5, 128'd10, 20, 1);
    vecs[3] = mk(0, 2'd0, {1'b1, 127'd0}, 0, 0, 0, {1'b0, {127{1'b1}}}, 5, 1);
    vecs[4] = mk(0, 2'd3, 0, 0, 0, 128'h12345678_9ABCDEF0_00000000_00000001,
                 128'h12345678_9ABCDEF0_00000000_00000001, 5, 0);

    repeat (2) tick();
    check("rst_data", out_data, 0);
    check("rst_ch", {126'd0, out_ch}, 0);
    check("rst_valid", {127'd0, out_valid}, 0);
    check("rst_busy", {127'd0, busy}, 0);
    check("rst_alarm", {127'd0, alarm}, 0);
    rst = 1'b0;
    tick();

    // NUM_CH=3 instance: out-of-range select clamps to channel 2, DWELL=1.
    sel1 = 2'd3; start1 = 1; tick(); start1 = 0;
    n = 0;
    while (!valid1 && n < 20) begin tick(); n++; end
    check("clamp_latency", n, 1);
    check("clamp_data", {112'd0, data1}, 128'hBEEF);
    check("clamp_ch", {126'd0, ch1}, 2);
    check("clamp_alarm", {127'd0, alarm1}, 0);
    repeat (2) tick();

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode; sel = vecs[i].sel; thresh = vecs[i].thr; ready = 1;
      for (int k = 0; k < 4; k++) chv[k] = vecs[i].d[k];
      push_run(vecs[i].mode, vecs[i].sel, vecs[i].thr, 1'b0);
      start = 1; tick(); start = 0;
      n = 0; first = -1;
      while (busy && n < 200) begin
        tick(); n++;
        if (out_valid && first < 0) first = n;
      end
      check($sformatf("vec%0d_latency", i), first, 4);
      check($sformatf("vec%0d_cycles", i), n, vecs[i].cycles);
      check($sformatf("vec%0d_alarm", i), {127'd0, alarm}, {127'd0, vecs[i].alarm});
      check($sformatf("vec%0d_drained", i), q.size(), 0);
      tick();
    end

    // Backpressure on ch0, with start_i pulsed during busy to show it is ignored.
    chv[0] = 1; chv[1] = 2; chv[2] = 3; chv[3] = 4;
    mode = 1; sel = 0; thresh = 100; ready = 0;
    push_run(1, 0, 100, 0);
    start = 1; tick(); start = 0;
    repeat (4) tick();
    check("bp_valid", {127'd0, out_valid}, 1);
    start = 1; mode = 0; sel = 3;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("bp_hold_data", out_data, 1);
      check("bp_hold_ch", {126'd0, out_ch}, 0);
    end
    start = 0; ready = 1;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("bp_done", {127'd0, busy}, 0);
    check("bp_drained", q.size(), 0);
    check("bp_last_ch", {126'd0, out_ch}, 3);
    check("bp_last_data", out_data, 4);
    check("bp_valid_low", {127'd0, out_valid}, 0);
    tick();

    // Asynchronous reset during the settle window of ch2.
    chv[0] = 'h11; chv[1] = 'h22; chv[2] = 'h33; chv[3] = 'h44;
    mode = 1; thresh = 0; ready = 1;
    push_run(1, 0, 0, 0);
    start = 1; tick(); start = 0;
    repeat (12) tick();
    check("mid_busy", {127'd0, busy}, 1);
    check("mid_alarm", {127'd0, alarm}, 1);
    check("mid_ch", {126'd0, out_ch}, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_data", out_data, 0);
    check("arst_ch", {126'd0, out_ch}, 0);
    check("arst_busy", {127'd0, busy}, 0);
    check("arst_alarm", {127'd0, alarm}, 0);
    q.delete();
    tick();
    rst = 1'b0;
    tick();

    // start_i at the last-channel handshake.
    chv[0] = 1; chv[1] = 2; chv[2] = 3; chv[3] = 50;
    mode = 1; sel = 0; thresh = 10; ready = 1;
    push_run(1, 0, 10, 0);
    start = 1; tick(); start = 0;
    repeat (19) tick();
    start = 1; mode = 0; sel = 1;
    tick();
    start = 0;
`ifdef SENSOR_SCAN_CONT_EN
    check("wrap_busy", {127'd0, busy}, 1);
    push_run(1, 0, 10, 1);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("wrap_cycles", n, 20);
`else
    check("last_idle", {127'd0, busy}, 0);
`endif
    check("last_alarm", {127'd0, alarm}, 1);
    check("last_drained", q.size(), 0);
    check("last_ch", {126'd0, out_ch}, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sensor_scan_mux.md
Name: sensor_scan_mux

Overview:
Parametrised multi-channel sensor sample mux for the SoC peripheral subsystem. It selects one of NUM_CH wide sensor/temperature channels, either a fixed channel or a sequential sweep. Each selected channel is held for a settle window, then sampled into a registered output. The output is delivered over a valid/ready handshake, and a sticky over-threshold alarm is maintained.

Parameters:
WIDTH, 128, bit width of each channel and of the output sample
NUM_CH, 4, number of input channels (>=2)
DWELL, 4, settle cycles per channel before capture (>=1)

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
ch_data_i  input  NUM_CH*WIDTH  packed channels; channel k = bits [k*WIDTH +: WIDTH]
mode_i  input  1  0 = fixed channel, 1 = sweep; latched at start
sel_i  input  $clog2(NUM_CH)  fixed-mode channel; latched at start
start_i  input  1  start request; accepted only in IDLE
thresh_i  input  WIDTH  unsigned alarm threshold; sampled at capture
out_data_o  output  WIDTH  captured sample
out_ch_o  output  $clog2(NUM_CH)  channel index of out_data_o
out_valid_o  output  1  sample available
out_ready_i  input  1  consumer accepts sample
busy_o  output  1  high whenever state != IDLE
alarm_o  output  1  sticky: some captured sample > thresh_i

Behaviour:
- Reset (async, any time including mid-sweep):
  - state = IDLE; out_data_o = 0, out_ch_o = 0, out_valid_o = 0, alarm_o = 0, busy_o = 0.
  - Internal channel and dwell counters = 0.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE, start_i = 1 at edge E:
  - Latch mode_i.
  - Channel = sel_i in fixed mode, clamped to NUM_CH-1 if sel_i >= NUM_CH; channel = 0 in sweep mode.
  - Clear dwell counter and clear alarm_o.
  - Go to SETTLE.
- SETTLE: dwell counter increments each edge. On the edge where counter == DWELL-1:
  - out_data_o <= ch_data_i[channel], out_ch_o <= channel, out_valid_o <= 1.
  - alarm_o <= alarm_o | (ch_data_i[channel] > thresh_i), unsigned compare.
  - Go to HOLD.
  - Resulting latency: out_valid_o rises after edge E+DWELL.
- HOLD:
  - While out_valid_o && !out_ready_i: out_data_o and out_ch_o stay stable.
  - On an edge with out_valid_o && out_ready_i: out_valid_o <= 0, then:
    - fixed mode: go to IDLE.
    - sweep mode, channel < NUM_CH-1: channel+1, dwell counter = 0, go to SETTLE.
    - sweep mode, channel == NUM_CH-1: go to IDLE.
- out_ready_i may already be high when out_valid_o rises; the handshake then completes on the next edge. There are no bubbles beyond the DWELL window per channel.
- start_i while busy_o = 1 is ignored, with no effect on latched mode or channel.
- out_data_o and out_ch_o retain their last values after the handshake and in IDLE; only out_valid_o drops.
- ch_data_i is sampled only at capture; changes during SETTLE are not observed.
- alarm_o is cleared only by rst or by an accepted start.

Optional Feature:
SENSOR_SCAN_CONT_EN
- Defined (continuous sweep): at the last-channel handshake in sweep mode, if start_i = 1 on that edge, channel wraps to 0 and the FSM goes to SETTLE (dwell = 0). alarm_o is NOT cleared on this wrap. If start_i = 0, go to IDLE.
- Undefined: the last-channel handshake always goes to IDLE; start_i has no effect there.

Test Plan:
- Fixed mode: sel_i=2, ch2=128'hA5, thresh=128'hFF, start at edge 0, ready=1 -> valid after edge 4; out_data=A5, out_ch=2, alarm=0; IDLE after edge 5.
- Sweep mode: ch0..3=1,2,3,4, ready=1 -> samples 1,2,3,4 on ch 0..3, valid after edges 4, 9, 14, 19; busy drops after edge 20.
- Backpressure: sweep with ready=0 for 6 cycles after the first valid -> out_data=1 and out_ch=0 held stable; no advance to ch1 until ready=1.
- Alarm: thresh=10, ch1=11, others 5, sweep -> alarm rises with the ch1 capture and stays 1; a new start clears it.
- Reset mid-operation: assert rst during SETTLE of ch2 -> all outputs 0 immediately (async); start_i held during busy is ignored.
- Boundary: sel_i=3 with NUM_CH=3 -> channel 2 captured. With SENSOR_SCAN_CONT_EN and start_i=1 at the last handshake -> next sample from ch0 and alarm is retained.
